// File: rtl/fetch_align_if.sv
// Handshake bundle between the fetch unit, fetch_align and the downstream decompressor.
// The slave modport is the fetch_align side; master is the side driving words and accepting instructions.
interface fetch_align_if #(
  parameter int XLEN = 32
);
  logic            word_valid_i;
  logic            word_ready_o;
  logic [31:0]     word_data_i;
  logic            instr_valid_o;
  logic            instr_ready_i;
  logic [31:0]     instr_o;
  logic            instr_is_c_o;
  logic [XLEN-1:0] instr_pc_o;

  modport master (
    output word_valid_i, word_data_i, instr_ready_i,
    input  word_ready_o, instr_valid_o, instr_o, instr_is_c_o, instr_pc_o
  );

  modport slave (
    input  word_valid_i, word_data_i, instr_ready_i,
    output word_ready_o, instr_valid_o, instr_o, instr_is_c_o, instr_pc_o
  );
endinterface

// File: rtl/fetch_align.sv
// Splits aligned 32-bit fetch words into 16/32-bit instructions through a 4-entry halfword queue,
// reassembling 32-bit instructions that straddle a word boundary and handling halfword redirects.
module fetch_align #(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            flush_i,
  input  logic [XLEN-1:0] flush_pc_i,
  fetch_align_if.slave    bus
);

  logic [15:0]     r_q [4];
  logic [1:0]      r_head;
  logic [2:0]      r_count;
  logic [XLEN-1:0] r_head_pc;
  logic            r_skip_lo;

  logic [15:0] w_h0;
  logic [15:0] w_h1;
  logic        w_h0_is_c;
  logic        w_instr_valid;
  logic        w_word_ready;
  logic        w_push;
  logic        w_pop;
  logic [2:0]  w_push_n;
  logic [2:0]  w_pop_n;
  logic [1:0]  w_tail;

  assign w_h0      = r_q[r_head];
  assign w_h1      = r_q[r_head + 2'd1];
  assign w_h0_is_c = (w_h0[1:0] != 2'b11);

  // A 32-bit instruction needs both halfwords queued; a lone low half stalls until the next word.
  assign w_instr_valid = w_h0_is_c ? (r_count >= 3'd1) : (r_count >= 3'd2);
  assign w_word_ready  = (r_count <= 3'd2);

  assign w_push   = bus.word_valid_i && w_word_ready;
  assign w_pop    = w_instr_valid && bus.instr_ready_i;
  assign w_push_n = !w_push ? 3'd0 : (r_skip_lo ? 3'd1 : 3'd2);
  assign w_pop_n  = !w_pop  ? 3'd0 : (w_h0_is_c ? 3'd1 : 3'd2);
  assign w_tail   = r_head + r_count[1:0];

  assign bus.word_ready_o  = w_word_ready;
  assign bus.instr_valid_o = w_instr_valid;
  assign bus.instr_pc_o    = r_head_pc;
  // Outputs are forced to zero on an empty queue so they stay defined and match the reset values.
  assign bus.instr_o       = (r_count == 3'd0) ? 32'h0 :
                             (w_h0_is_c ? {16'h0, w_h0} : {w_h1, w_h0});
  assign bus.instr_is_c_o  = (r_count != 3'd0) && w_h0_is_c;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      // NOTE: the queue storage is reset too, so instr_o never carries X even from stale slots.
      for (int i = 0; i < 4; i++) r_q[i] <= '0;
      r_head    <= '0;
      r_count   <= '0;
      r_head_pc <= RESET_PC & ~XLEN'(1);
      r_skip_lo <= RESET_PC[1];
    end else if (flush_i) begin
      // Redirect wins over both handshakes: nothing is pushed, popped or advanced this cycle.
      r_count   <= '0;
      r_head_pc <= flush_pc_i & ~XLEN'(1);
      r_skip_lo <= flush_pc_i[1];
    end else begin
      // NOTE: non-blocking updates let push and pop both use the pre-edge head and count.
      if (w_push) begin
        if (r_skip_lo) begin
          r_q[w_tail] <= bus.word_data_i[31:16];
          r_skip_lo   <= 1'b0;
        end else begin
          r_q[w_tail]        <= bus.word_data_i[15:0];
          r_q[w_tail + 2'd1] <= bus.word_data_i[31:16];
        end
      end
      if (w_pop) begin
        r_head    <= r_head + w_pop_n[1:0];
        r_head_pc <= r_head_pc + XLEN'({w_pop_n, 1'b0});
      end
      r_count <= r_count + w_push_n - w_pop_n;
    end
  end

endmodule

// File: tb/tb_fetch_align.sv
// Self-checking bench for fetch_align: directed vector table, hand-written corner sequences,
// and a randomized run against a halfword-queue reference model.
module tb_fetch_align;

  logic        clk;
  logic        reset_n;
  logic        flush_i;
  logic [31:0] flush_pc_i;

  fetch_align_if #(.XLEN(32)) u_if ();

  fetch_align #(.XLEN(32), .RESET_PC(32'h0)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .flush_i    (flush_i),
    .flush_pc_i (flush_pc_i),
    .bus        (u_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic        flush;
    logic [31:0] fpc;
    logic        wv;
    logic [31:0] wd;
    logic        ir;
    logic        e_valid;
    logic [31:0] e_instr;
    logic        e_is_c;
    logic [31:0] e_pc;
    logic        e_wready;
  } vec_t;

  vec_t vecs [16];

  // Reference model state: plain queue of halfwords plus PC and skip flag.
  logic [15:0] mq [$];
  logic [31:0] m_pc;
  logic        m_skip;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic fl, input logic [31:0] fpc, input logic wv,
                       input logic [31:0] wd, input logic ir);
    flush_i          = fl;
    flush_pc_i       = fpc;
    u_if.word_valid_i  = wv;
    u_if.word_data_i   = wd;
    u_if.instr_ready_i = ir;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic check_out(input string tag, input logic ev, input logic [31:0] ei,
                           input logic ec, input logic [31:0] ep, input logic ew);
    check({tag, " valid"},  32'(u_if.instr_valid_o), 32'(ev));
    check({tag, " pc"},     u_if.instr_pc_o, ep);
    check({tag, " wready"}, 32'(u_if.word_ready_o), 32'(ew));
    if (ev) begin
      check({tag, " instr"}, u_if.instr_o, ei);
      check({tag, " is_c"},  32'(u_if.instr_is_c_o), 32'(ec));
    end
  endtask

  initial begin
    vecs[0]  = '{1'b0, 32'h0,   1'b1, 32'h00A00093, 1'b1, 1'b0, 32'h0,        1'b0, 32'h0,   1'b1};
    vecs[1]  = '{1'b0, 32'h0,   1'b1, 32'h45014505, 1'b1, 1'b1, 32'h00A00093, 1'b0, 32'h0,   1'b1};
    vecs[2]  = '{1'b0, 32'h0,   1'b0, 32'h0,        1'b1, 1'b1, 32'h00004505, 1'b1, 32'h4,   1'b1};
    vecs[3]  = '{1'b0, 32'h0,   1'b0, 32'h0,        1'b1, 1'b1, 32'h00004501, 1'b1, 32'h6,   1'b1};
    vecs[4]  = '{1'b0, 32'h0,   1'b0, 32'h0,        1'b1, 1'b0, 32'h0,        1'b0, 32'h8,   1'b1};
    vecs[5]  = '{1'b1, 32'h0,   1'b0, 32'h0,        1'b1, 1'b0, 32'h0,        1'b0, 32'h8,   1'b1};
    vecs[6]  = '{1'b0, 32'h0,   1'b1, 32'h00934505, 1'b1, 1'b0, 32'h0,        1'b0, 32'h0,   1'b1};
    vecs[7]  = '{1'b0, 32'h0,   1'b0, 32'h0,        1'b1, 1'b1, 32'h00004505, 1'b1, 32'h0,   1'b1};
    vecs[8]  = '{1'b0, 32'h0,   1'b0, 32'h0,        1'b1, 1'b0, 32'h0,        1'b0, 32'h2,   1'b1};
    vecs[9]  = '{1'b0, 32'h0,   1'b1, 32'h450500A0, 1'b1, 1'b0, 32'h0,        1'b0, 32'h2,   1'b1};
    vecs[10] = '{1'b0, 32'h0,   1'b0, 32'h0,        1'b1, 1'b1, 32'h00A00093, 1'b0, 32'h2,   1'b0};
    vecs[11] = '{1'b0, 32'h0,   1'b0, 32'h0,        1'b1, 1'b1, 32'h00004505, 1'b1, 32'h6,   1'b1};
    vecs[12] = '{1'b1, 32'h102, 1'b0, 32'h0,        1'b1, 1'b0, 32'h0,        1'b0, 32'h8,   1'b1};
    vecs[13] = '{1'b0, 32'h0,   1'b1, 32'h4501DEAD, 1'b1, 1'b0, 32'h0,        1'b0, 32'h102, 1'b1};
    vecs[14] = '{1'b0, 32'h0,   1'b0, 32'h0,        1'b1, 1'b1, 32'h00004501, 1'b1, 32'h102, 1'b1};
    vecs[15] = '{1'b0, 32'h0,   1'b0, 32'h0,        1'b1, 1'b0, 32'h0,        1'b0, 32'h104, 1'b1};

    // Reset values while reset_n is held low.
    reset_n = 1'b0;
    drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    #1;
    check("reset valid",  32'(u_if.instr_valid_o), 32'h0);
    check("reset wready", 32'(u_if.word_ready_o), 32'h1);
    check("reset instr",  u_if.instr_o, 32'h0);
    check("reset is_c",   32'(u_if.instr_is_c_o), 32'h0);
    check("reset pc",     u_if.instr_pc_o, 32'h0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;

    // Directed table: aligned mix, straddling 32-bit, halfword flush target.
    for (int i = 0; i < 16; i++) begin
      drive(vecs[i].flush, vecs[i].fpc, vecs[i].wv, vecs[i].wd, vecs[i].ir);
      check_out($sformatf("vec%0d", i), vecs[i].e_valid, vecs[i].e_instr,
                vecs[i].e_is_c, vecs[i].e_pc, vecs[i].e_wready);
      @(negedge clk);
    end

    // Backpressure: fill to 4 halfwords, hold, then drain.
    do_reset();
    drive(1'b0, 32'h0, 1'b1, 32'h00A00093, 1'b0);
    repeat (2) @(negedge clk);
    check_out("bp full", 1'b1, 32'h00A00093, 1'b0, 32'h0, 1'b0);
    @(negedge clk);
    check_out("bp hold", 1'b1, 32'h00A00093, 1'b0, 32'h0, 1'b0);
    drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
    @(negedge clk);
    check_out("bp pop1", 1'b1, 32'h00A00093, 1'b0, 32'h4, 1'b1);
    @(negedge clk);
    check_out("bp empty", 1'b0, 32'h0, 1'b0, 32'h8, 1'b1);

    // Asynchronous reset with three halfwords queued.
    do_reset();
    drive(1'b0, 32'h0, 1'b1, 32'h45054505, 1'b0);
    @(negedge clk);
    u_if.instr_ready_i = 1'b1;
    @(negedge clk);
    check_out("mid count3", 1'b1, 32'h00004505, 1'b1, 32'h2, 1'b0);
    drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    #2 reset_n = 1'b0;
    #1;
    check("async valid",  32'(u_if.instr_valid_o), 32'h0);
    check("async wready", 32'(u_if.word_ready_o), 32'h1);
    check("async pc",     u_if.instr_pc_o, 32'h0);
    @(negedge clk);
    reset_n = 1'b1;
    drive(1'b0, 32'h0, 1'b1, 32'h00A00093, 1'b1);
    @(negedge clk);
    u_if.word_valid_i = 1'b0;
    check_out("post reset", 1'b1, 32'h00A00093, 1'b0, 32'h0, 1'b1);
    @(negedge clk);
    check_out("post reset2", 1'b0, 32'h0, 1'b0, 32'h4, 1'b1);

    // Flush colliding with both handshakes.
    do_reset();
    drive(1'b0, 32'h0, 1'b1, 32'h45054505, 1'b1);
    @(negedge clk);
    check_out("coll pre", 1'b1, 32'h00004505, 1'b1, 32'h0, 1'b1);
    drive(1'b1, 32'h40, 1'b1, 32'h00A00093, 1'b1);
    @(negedge clk);
    drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
    check_out("coll flush", 1'b0, 32'h0, 1'b0, 32'h40, 1'b1);
    @(negedge clk);
    check_out("coll idle", 1'b0, 32'h0, 1'b0, 32'h40, 1'b1);
    drive(1'b0, 32'h0, 1'b1, 32'h45014501, 1'b1);
    @(negedge clk);
    u_if.word_valid_i = 1'b0;
    check_out("coll new0", 1'b1, 32'h00004501, 1'b1, 32'h40, 1'b1);
    @(negedge clk);
    check_out("coll new1", 1'b1, 32'h00004501, 1'b1, 32'h42, 1'b1);
    @(negedge clk);
    check_out("coll end", 1'b0, 32'h0, 1'b0, 32'h44, 1'b1);

    // Randomized run against the queue model.
    do_reset();
    mq.delete();
    m_pc   = 32'h0;
    m_skip = 1'b0;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      logic        e_valid, e_is_c, e_wready, fl, wv, ir;
      logic [31:0] e_instr, fpc, wd;
      e_wready = (mq.size() <= 2);
      e_valid  = 1'b0;
      e_is_c   = 1'b0;
      e_instr  = 32'h0;
      if (mq.size() > 0) begin
        e_is_c  = (mq[0][1:0] != 2'b11);
        e_valid = e_is_c ? 1'b1 : (mq.size() >= 2);
        if (e_valid) e_instr = e_is_c ? {16'h0, mq[0]} : {mq[1], mq[0]};
      end
      check_out($sformatf("rnd%0d", cyc), e_valid, e_instr, e_is_c, m_pc, e_wready);

      fl  = ($urandom_range(0, 99) < 3);
      fpc = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | ($urandom() & 32'hF)) : $urandom();
      wv  = ($urandom_range(0, 99) < 60);
      wd  = $urandom();
      ir  = ($urandom_range(0, 99) < 70);
      drive(fl, fpc, wv, wd, ir);

      if (fl) begin
        mq.delete();
        m_pc   = fpc & ~32'h1;
        m_skip = fpc[1];
      end else begin
        if (e_valid && ir) begin
          void'(mq.pop_front());
          if (!e_is_c) void'(mq.pop_front());
          m_pc = m_pc + (e_is_c ? 32'd2 : 32'd4);
        end
        if (wv && e_wready) begin
          if (!m_skip) mq.push_back(wd[15:0]);
          mq.push_back(wd[31:16]);
          m_skip = 1'b0;
        end
      end
      @(negedge clk);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
